// File: rtl/sar_ctrl.sv
// sar_ctrl: sequencing controller for the SAR ADC model.
// It steps through precharge, sample and convert, runs the binary search
// against the comparator, and presents each finished code with a valid strobe.
module sar_ctrl #(
    parameter int N_BITS      = 8,
    parameter int SMPL_CYCLES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              i_cmp,
    input  real               i_Vref_H,
    input  real               i_Vref_L,
    output logic              o_Sprg,
    output logic              o_Ssmpl,
    output logic [N_BITS-1:0] o_code,
    output real               o_Vdac_mat,
    output logic [N_BITS-1:0] o_result,
    output logic              o_valid,
    output logic              o_busy
);

    localparam int BW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam int CW = (SMPL_CYCLES > 1) ? $clog2(SMPL_CYCLES) : 1;
    localparam logic [BW-1:0] BIT_TOP   = BW'(N_BITS - 1);
    localparam logic [CW-1:0] SMPL_LAST = CW'(SMPL_CYCLES - 1);
    localparam real FULL_SCALE = real'(64'd1 << N_BITS);

    typedef enum logic [2:0] {
        IDLE,
        PRECHG,
        SAMPLE,
        CONVERT,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     smpl_q, smpl_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [N_BITS-1:0] code_q, code_d;
    logic [N_BITS-1:0] result_q, result_d;

    // Registers for the state, counters, trial code and last result.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            smpl_q   <= '0;
            bit_q    <= '0;
            code_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            smpl_q   <= smpl_d;
            bit_q    <= bit_d;
            code_q   <= code_d;
            result_q <= result_d;
        end
    end

    // Next state plus the search step: keep the tested bit only if Vin is at
    // or above the trial voltage, then try the next lower bit.
    always_comb begin
        state_d  = state_q;
        smpl_d   = smpl_q;
        bit_d    = bit_q;
        code_d   = code_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = PRECHG;
                    code_d  = '0;
                end
            end
            PRECHG: begin
                state_d = SAMPLE;
                smpl_d  = '0;
            end
            SAMPLE: begin
                if (smpl_q == SMPL_LAST) begin
                    state_d             = CONVERT;
                    code_d              = '0;
                    code_d[N_BITS-1]    = 1'b1;
                    bit_d               = BIT_TOP;
                end else begin
                    smpl_d = smpl_q + 1'b1;
                end
            end
            CONVERT: begin
                code_d[bit_q] = i_cmp;
                if (bit_q != '0) begin
                    code_d[bit_q - 1'b1] = 1'b1;
                    bit_d                = bit_q - 1'b1;
                end else begin
                    state_d  = DONE;
                    result_d = code_d;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (i_abort && (state_q != IDLE)) begin
            state_d  = IDLE;
            code_d   = '0;
            result_d = result_q;
        end
    end

    assign o_Sprg     = (state_q == PRECHG);
    assign o_Ssmpl    = (state_q == SAMPLE);
    assign o_valid    = (state_q == DONE);
    assign o_busy     = (state_q != IDLE);
    assign o_code     = code_q;
    assign o_result   = result_q;
    assign o_Vdac_mat = i_Vref_L + real'(o_code) * (i_Vref_H - i_Vref_L) / FULL_SCALE;

endmodule
